// File: rtl/wdg_pkg.sv
// Shared definitions for the watchdog block family: bus FSM encodings, register map and reset defaults.
// Pure declarations; no logic or timing of its own.
package wdg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10
    } bus_state_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } str_state_t;

    localparam logic [31:0] CSR_OFS = 32'h0000_0000;
    localparam logic [31:0] CFG_OFS = 32'h0000_0004;
    localparam logic [31:0] IRQ_OFS = 32'h0000_0008;

    localparam int CSR_WWDGF = 0;
    localparam int CSR_IWDGF = 1;
    localparam int CSR_SWF   = 2;
    localparam int CSR_SWRST = 6;
    localparam int CSR_RMVF  = 7;

    localparam int IRQ_EWIF  = 0;
    localparam int IRQ_EWIE  = 1;

    localparam logic [7:0] LEN_RST = 8'd15;

endpackage

// File: rtl/wdg_rst_ctrl_if.sv
// Wishbone-style slave bus shared by the watchdog blocks.
// Ack comes one cycle after cyc is sampled; the slave never stalls beyond that.
interface wdg_rst_ctrl_if #(
  parameter int DAT_SIZE = 8
);
  logic [DAT_SIZE-1:0] dat_m2s;
  logic [31:0]         adr_m2s;
  logic                cyc_m2s;
  logic                we_m2s;
  logic                stb_m2s;
  logic [DAT_SIZE-1:0] dat_s2m;
  logic                ack_s2m;

  modport master (
    output dat_m2s, adr_m2s, cyc_m2s, we_m2s, stb_m2s,
    input  dat_s2m, ack_s2m
  );

  modport slave (
    input  dat_m2s, adr_m2s, cyc_m2s, we_m2s, stb_m2s,
    output dat_s2m, ack_s2m
  );
endinterface

// File: rtl/rst_stretch.sv
// Reset pulse stretcher: pulse_out rises the cycle after src is sampled high and stays high
// for len+1 cycles after the last high src cycle; no input backpressure, src retriggers reload.
module rst_stretch
  import wdg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       src,
  input  logic [7:0] len,
  output logic       pulse_out
);

  str_state_t state;
  logic [7:0] cnt;

  // pulse_out tracks the next state so the output is registered yet only one cycle behind src.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= 8'd0;
      pulse_out <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (src) begin
            state     <= HOLD;
            cnt       <= len;
            pulse_out <= 1'b1;
          end else begin
            pulse_out <= 1'b0;
          end
        end
        HOLD: begin
          if (src) begin
            cnt       <= len;
            pulse_out <= 1'b1;
          end else if (cnt == 8'd0) begin
            state     <= RUN;
            pulse_out <= 1'b0;
          end else begin
            cnt       <= cnt - 8'd1;
            pulse_out <= 1'b1;
          end
        end
        default: begin
          state     <= RUN;
          pulse_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/wdg_rst_ctrl.sv
// Watchdog reset/interrupt controller: stretched sys_rst, maskable irq, sticky cause flags on the bus.
// Bus ack one cycle after cyc; sys_rst one cycle after a source; flags survive sys_rst (only rst clears).
module wdg_rst_ctrl
  import wdg_pkg::*;
#(
  parameter int          DAT_SIZE     = 8,
  parameter logic [31:0] BASE_ADR     = 32'h0110_0100,
  parameter logic [31:0] RSTC_CSR_ADR = BASE_ADR + CSR_OFS,
  parameter logic [31:0] RSTC_CFG_ADR = BASE_ADR + CFG_OFS,
  parameter logic [31:0] RSTC_IRQ_ADR = BASE_ADR + IRQ_OFS
) (
  input  logic           clk,
  input  logic           rst,
  wdg_rst_ctrl_if.slave  bus,
  input  logic           wwdg_rst,
  input  logic           wwdg_ewi,
  input  logic           iwdg_rst,
  output logic           sys_rst,
  output logic           irq
);

  bus_state_t state;

  logic       wwdgf, iwdgf, swf;
  logic       ewif, ewie;
  logic [7:0] len;

  logic       in_xfer, wr_en;
  logic       wr_csr, wr_cfg, wr_irq;
  logic       swrst_pulse, rmvf;
  logic       src;
  logic [7:0] rd_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (bus.cyc_m2s) state <= bus.we_m2s ? WRITE : READ;
        READ:    state <= IDLE;
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_xfer     = (state == READ) || (state == WRITE);
  assign bus.ack_s2m = in_xfer & bus.cyc_m2s & bus.stb_m2s;

  assign wr_en  = (state == WRITE) & bus.cyc_m2s & bus.stb_m2s;
  assign wr_csr = wr_en & (bus.adr_m2s == RSTC_CSR_ADR);
  assign wr_cfg = wr_en & (bus.adr_m2s == RSTC_CFG_ADR);
  assign wr_irq = wr_en & (bus.adr_m2s == RSTC_IRQ_ADR);

  assign swrst_pulse = wr_csr & bus.dat_m2s[CSR_SWRST];
  assign rmvf        = wr_csr & bus.dat_m2s[CSR_RMVF];
  assign src         = wwdg_rst | iwdg_rst | swrst_pulse;

  // Each flag's set term is ORed after the clear so a simultaneous event is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      wwdgf <= 1'b0;
      iwdgf <= 1'b0;
      swf   <= 1'b0;
      ewif  <= 1'b0;
      ewie  <= 1'b0;
      len   <= LEN_RST;
      irq   <= 1'b0;
    end else begin
      wwdgf <= wwdg_rst    | (wwdgf & ~rmvf);
      iwdgf <= iwdg_rst    | (iwdgf & ~rmvf);
      swf   <= swrst_pulse | (swf   & ~rmvf);
      ewif  <= wwdg_ewi    | (ewif  & ~(wr_irq & bus.dat_m2s[IRQ_EWIF]));
      if (wr_irq) ewie <= bus.dat_m2s[IRQ_EWIE];
      if (wr_cfg) len  <= bus.dat_m2s[7:0];
      irq   <= ewif & ewie;
    end
  end

  always_comb begin
    rd_dat = 8'h00;
    if (state == READ) begin
      if (bus.adr_m2s == RSTC_CSR_ADR) begin
        rd_dat[CSR_WWDGF] = wwdgf;
        rd_dat[CSR_IWDGF] = iwdgf;
        rd_dat[CSR_SWF]   = swf;
      end else if (bus.adr_m2s == RSTC_CFG_ADR) begin
        rd_dat = len;
      end else if (bus.adr_m2s == RSTC_IRQ_ADR) begin
        rd_dat[IRQ_EWIF] = ewif;
        rd_dat[IRQ_EWIE] = ewie;
      end
    end
  end

  assign bus.dat_s2m = DAT_SIZE'(rd_dat);

  rst_stretch u_stretch (
    .clk       (clk),
    .rst       (rst),
    .src       (src),
    .len       (len),
    .pulse_out (sys_rst)
  );

endmodule

// File: tb/tb_wdg_rst_ctrl.sv
// Bench for wdg_rst_ctrl: register table, scoreboarded bus reads and cycle-level sys_rst/irq sequences.
module tb_wdg_rst_ctrl;

  localparam logic [31:0] BASE = 32'h0110_0100;
  localparam logic [31:0] CSR  = BASE + 32'h0;
  localparam logic [31:0] CFG  = BASE + 32'h4;
  localparam logic [31:0] IRQ  = BASE + 32'h8;
  localparam logic [31:0] UNM  = BASE + 32'hC;

  logic clk = 1'b0;
  logic rst;
  logic wwdg_rst, wwdg_ewi, iwdg_rst;
  logic sys_rst, irq;

  wdg_rst_ctrl_if #(.DAT_SIZE(8)) bus ();

  wdg_rst_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .wwdg_rst (wwdg_rst),
    .wwdg_ewi (wwdg_ewi),
    .iwdg_rst (iwdg_rst),
    .sys_rst  (sys_rst),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [7:0]  wdat;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Holds cyc through the edge that ends the ack cycle so writes commit, then drops it.
  task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [7:0] wdat,
                          output logic [7:0] rdat, output logic got);
    got  = 1'b0;
    rdat = 8'h00;
    @(negedge clk);
    bus.cyc_m2s = 1'b1;
    bus.stb_m2s = 1'b1;
    bus.we_m2s  = we;
    bus.adr_m2s = adr;
    bus.dat_m2s = wdat;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (bus.ack_s2m) begin
        got  = 1'b1;
        rdat = bus.dat_s2m;
        break;
      end
    end
    if (got) begin
      @(posedge clk); #1;
    end
    bus.cyc_m2s = 1'b0;
    bus.stb_m2s = 1'b0;
    bus.we_m2s  = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] adr, input logic [7:0] wdat, input string name);
    logic [7:0] r;
    logic       g;
    bus_xfer(1'b1, adr, wdat, r, g);
    check({name, "_ack"}, {31'd0, g}, 32'd1);
  endtask

  task automatic bus_read(input logic [31:0] adr, input logic [7:0] exp, input string name);
    logic [7:0] r;
    logic [7:0] e;
    logic       g;
    exp_q.push_back(exp);
    bus_xfer(1'b0, adr, 8'h00, r, g);
    check({name, "_ack"}, {31'd0, g}, 32'd1);
    e = exp_q.pop_front();
    if (g) check(name, {24'd0, r}, {24'd0, e});
  endtask

  // Expected sys_rst at each negedge: high iff some earlier src cycle lies within len+1 cycles.
  task automatic run_pattern(input logic [15:0] pat, input int npat, input int len, input string name);
    int   last_hi;
    logic e;
    last_hi = -1000;
    for (int i = 0; i < npat + len + 4; i++) begin
      @(negedge clk);
      e = ((i - last_hi) <= (len + 1));
      check($sformatf("%s_c%0d", name, i), {31'd0, sys_rst}, {31'd0, e});
      iwdg_rst = (i < npat) ? pat[i] : 1'b0;
      if (iwdg_rst) last_hi = i;
    end
    iwdg_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int cnt;

    vt[0] = '{1'b0, CSR, 8'h00, 8'h00, "rst_csr"};
    vt[1] = '{1'b0, CFG, 8'h00, 8'h0F, "rst_cfg"};
    vt[2] = '{1'b0, IRQ, 8'h00, 8'h00, "rst_irq"};
    vt[3] = '{1'b0, UNM, 8'h00, 8'h00, "rst_unm"};
    vt[4] = '{1'b1, CFG, 8'h5A, 8'h00, "wr_cfg5a"};
    vt[5] = '{1'b0, CFG, 8'h00, 8'h5A, "rd_cfg5a"};
    vt[6] = '{1'b1, UNM, 8'hFF, 8'h00, "wr_unm"};
    vt[7] = '{1'b0, CFG, 8'h00, 8'h5A, "rd_cfg_after_unm"};
    vt[8] = '{1'b1, CFG, 8'h0F, 8'h00, "wr_cfg0f"};
    vt[9] = '{1'b0, CFG, 8'h00, 8'h0F, "rd_cfg0f"};

    rst = 1'b1;
    wwdg_rst = 1'b0; wwdg_ewi = 1'b0; iwdg_rst = 1'b0;
    bus.cyc_m2s = 1'b0; bus.stb_m2s = 1'b0; bus.we_m2s = 1'b0;
    bus.adr_m2s = '0; bus.dat_m2s = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sys_rst", {31'd0, sys_rst}, 32'd0);
    check("rst_irq_out", {31'd0, irq}, 32'd0);
    check("rst_ack", {31'd0, bus.ack_s2m}, 32'd0);
    check("rst_dat", {24'd0, bus.dat_s2m}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[k]) begin
      if (vt[k].we) bus_write(vt[k].adr, vt[k].wdat, vt[k].name);
      else          bus_read(vt[k].adr, vt[k].exp, vt[k].name);
    end

    // One-cycle wwdg_rst with LEN=15: 16-cycle pulse.
    @(negedge clk);
    wwdg_rst = 1'b1;
    check("wwdg_pre", {31'd0, sys_rst}, 32'd0);
    @(negedge clk);
    wwdg_rst = 1'b0;
    cnt = 0;
    while (sys_rst && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("wwdg_len", cnt, 16);
    bus_read(CSR, 8'h01, "wwdg_csr");
    bus_write(CSR, 8'h80, "wwdg_rmvf");
    bus_read(CSR, 8'h00, "wwdg_csr_clr");

    // iwdg held 5 cycles, gap of 3, retrigger, LEN=4.
    bus_write(CFG, 8'h04, "cfg4");
    run_pattern(16'h011F, 9, 4, "iwdg");
    bus_read(CSR, 8'h02, "iwdg_csr");
    bus_write(CSR, 8'h80, "iwdg_rmvf");

    // Software reset with LEN=0.
    bus_write(CFG, 8'h00, "cfg0");
    bus_write(CSR, 8'h40, "swrst");
    check("swrst_hi", {31'd0, sys_rst}, 32'd1);
    @(posedge clk); #1;
    check("swrst_lo", {31'd0, sys_rst}, 32'd0);
    bus_read(CSR, 8'h04, "swrst_csr");
    bus_write(CSR, 8'h80, "sw_rmvf");
    bus_read(CSR, 8'h00, "sw_csr_clr");

    // Early-wakeup interrupt masking and set-over-clear.
    @(negedge clk);
    wwdg_ewi = 1'b1;
    @(negedge clk);
    wwdg_ewi = 1'b0;
    repeat (2) @(negedge clk);
    check("ewi_masked", {31'd0, irq}, 32'd0);
    bus_read(IRQ, 8'h01, "ewi_irqreg");
    bus_write(IRQ, 8'h02, "ewie_set");
    check("irq_lat0", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq_lat1", {31'd0, irq}, 32'd1);
    @(negedge clk);
    wwdg_ewi = 1'b1;
    bus_write(IRQ, 8'h03, "ewif_clr_vs_set");
    @(negedge clk);
    wwdg_ewi = 1'b0;
    bus_read(IRQ, 8'h03, "ewif_kept");
    bus_write(IRQ, 8'h01, "ewif_clr");
    bus_read(IRQ, 8'h00, "irq_cleared");
    @(posedge clk); #1;
    check("irq_off", {31'd0, irq}, 32'd0);

    // rst mid-HOLD with flags set.
    bus_write(CFG, 8'd20, "cfg20");
    @(negedge clk);
    wwdg_rst = 1'b1; wwdg_ewi = 1'b1;
    @(negedge clk);
    wwdg_rst = 1'b0; wwdg_ewi = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_before_rst", {31'd0, sys_rst}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_drop", {31'd0, sys_rst}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_read(CSR, 8'h00, "post_rst_csr");
    bus_read(IRQ, 8'h00, "post_rst_irq");
    bus_read(CFG, 8'h0F, "post_rst_cfg");
    bus_read(UNM, 8'h00, "unmapped");
    check("post_rst_sys", {31'd0, sys_rst}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
